ram_port_responder: RTL and testbench

Clocked responder for the RAM control protocol (CS/WE/OE strobes, ADDRESS, DATA). It owns a `2**Address_size x Word_size` storage array. Writes complete in one cycle. Reads complete after a fixed latency, signalled by a one-cycle valid pulse. It is the target-side counterpart to the bench/BIST logic that issues write and read strobes, and lets those initiators run against a synchronous, cycle-exact memory model.

---
 rtl/ram_port_responder.sv | 97 +++++++++
 tb/tb_ram_port_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram_port_responder.sv
// Cycle-exact target for the RAM strobe protocol: single-cycle writes, fixed-latency
// reads reported by a one-cycle OUT_VALID pulse, with never-written tracking.
module ram_port_responder #(
   parameter int Address_size = 2,
   parameter int Word_size    = 3,
   parameter int Read_latency = 2
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    CS,
   input  logic                    WE,
   input  logic                    OE,
   input  logic [Address_size-1:0] ADDRESS,
   input  logic [Word_size-1:0]    DATA,
   output logic [Word_size-1:0]    OUT,
   output logic                    OUT_VALID,
   output logic                    UNINIT,
   output logic                    BUSY,
   output logic                    ERR
);

   localparam int Depth = 2 ** Address_size;

   typedef enum logic {IDLE, READ} state_t;

   state_t                  state, next_state;
   logic [2:0]              cnt;
   logic [Address_size-1:0] rd_addr;
   logic [Word_size-1:0]    mem [Depth];
   logic [Depth-1:0]        written;

   logic do_write, do_read, do_err, complete;

   always_ff @(posedge CLK) begin
      if (!RESET_N) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      BUSY       = 1'b0;
      do_write   = 1'b0;
      do_read    = 1'b0;
      do_err     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (CS) begin
               do_write = WE && !OE;
               do_read  = OE && !WE;
               do_err   = WE && OE;
            end
            if (do_read) next_state = READ;
         end
         READ: begin
            BUSY = 1'b1;
            if (cnt == 3'd0) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Read data is sampled from the array at completion, not at acceptance.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         cnt       <= '0;
         rd_addr   <= '0;
         mem       <= '{default: '0};
         written   <= '0;
         OUT       <= '0;
         OUT_VALID <= 1'b0;
         UNINIT    <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         OUT_VALID <= complete;
         ERR       <= do_err;
         if (do_write) begin
            mem[ADDRESS]     <= DATA;
            written[ADDRESS] <= 1'b1;
         end
         if (do_read) begin
            rd_addr <= ADDRESS;
            cnt     <= 3'(Read_latency - 1);
         end else if (state == READ && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
         if (complete) begin
            OUT    <= written[rd_addr] ? mem[rd_addr] : '0;
            UNINIT <= !written[rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_ram_port_responder.sv
// Scoreboard bench: two responders (read latency 2 and 1); stimulus queues expected
// read results, negedge monitors pop and compare whenever OUT_VALID is seen.
module tb_ram_port_responder;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic            RESET_N;
   logic [1:0]      cs, we, oe;
   logic [1:0][1:0] addr;
   logic [1:0][2:0] data;
   logic [1:0][2:0] out;
   logic [1:0]      ov, un, busy, err;

   int cyc = 0;
   int pass = 0;
   int total = 0;

   typedef struct {
      logic [2:0] d;
      logic       u;
      int         c;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always @(posedge CLK) cyc <= cyc + 1;

   ram_port_responder #(.Address_size(2), .Word_size(3), .Read_latency(2)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CS(cs[0]), .WE(we[0]), .OE(oe[0]),
      .ADDRESS(addr[0]), .DATA(data[0]), .OUT(out[0]), .OUT_VALID(ov[0]),
      .UNINIT(un[0]), .BUSY(busy[0]), .ERR(err[0])
   );

   ram_port_responder #(.Address_size(2), .Word_size(3), .Read_latency(1)) dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .CS(cs[1]), .WE(we[1]), .OE(oe[1]),
      .ADDRESS(addr[1]), .DATA(data[1]), .OUT(out[1]), .OUT_VALID(ov[1]),
      .UNINIT(un[1]), .BUSY(busy[1]), .ERR(err[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic int lat(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   task automatic idle(input int u);
      cs[u] = 1'b0;
      we[u] = 1'b0;
      oe[u] = 1'b0;
   endtask

   task automatic wr(input int u, input int a, input int d);
      cs[u] = 1'b1; we[u] = 1'b1; oe[u] = 1'b0;
      addr[u] = 2'(a);
      data[u] = 3'(d);
      step();
      idle(u);
   endtask

   task automatic rd_start(input int u, input int a, input int d, input int uninit, input bit expect_valid);
      exp_t e;
      cs[u] = 1'b1; oe[u] = 1'b1; we[u] = 1'b0;
      addr[u] = 2'(a);
      e.d = 3'(d);
      e.u = uninit[0];
      e.c = cyc + 1 + lat(u);
      if (expect_valid) begin
         if (u == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      step();
      idle(u);
      chk("busy_after_accept", int'(busy[u]), 1);
   endtask

   task automatic rd_finish(input int u);
      repeat (lat(u)) step();
      chk("busy_clear_at_completion", int'(busy[u]), 0);
   endtask

   task automatic rd(input int u, input int a, input int d, input int uninit);
      rd_start(u, a, d, uninit, 1'b1);
      rd_finish(u);
   endtask

   // Monitors: every OUT_VALID must match the oldest queued expectation, in value and cycle.
   always @(negedge CLK) begin
      if (ov[0]) begin
         if (q0.size() == 0) chk("unexpected_valid_l2", 1, 0);
         else begin
            exp_t e;
            e = q0.pop_front();
            chk("out_l2", int'(out[0]), int'(e.d));
            chk("uninit_l2", int'(un[0]), int'(e.u));
            chk("valid_cycle_l2", cyc, e.c);
            chk("no_err_with_valid_l2", int'(err[0]), 0);
         end
      end
      if (ov[1]) begin
         if (q1.size() == 0) chk("unexpected_valid_l1", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("out_l1", int'(out[1]), int'(e.d));
            chk("uninit_l1", int'(un[1]), int'(e.u));
            chk("valid_cycle_l1", cyc, e.c);
         end
      end
   end

   initial begin
      RESET_N = 1'b0;
      cs = '0; we = '0; oe = '0; addr = '0; data = '0;
      step();
      step();
      for (int u = 0; u < 2; u++) begin
         chk("reset_out", int'(out[u]), 0);
         chk("reset_valid", int'(ov[u]), 0);
         chk("reset_uninit", int'(un[u]), 0);
         chk("reset_busy", int'(busy[u]), 0);
         chk("reset_err", int'(err[u]), 0);
      end
      RESET_N = 1'b1;

      for (int a = 0; a < 4; a++) rd(0, a, 0, 1);

      wr(0, 0, 1);
      wr(0, 1, 2);
      wr(0, 2, 3);
      wr(0, 3, 4);
      for (int a = 0; a < 4; a++) rd(0, a, a + 1, 0);

      // Write presented while busy must be ignored.
      rd_start(0, 1, 2, 0, 1'b1);
      cs[0] = 1'b1; we[0] = 1'b1; oe[0] = 1'b0; addr[0] = 2'd1; data[0] = 3'd7;
      step();
      idle(0);
      step();
      chk("busy_clear_after_ignored_write", int'(busy[0]), 0);
      rd(0, 1, 2, 0);

      // WE and OE together: ERR pulse only.
      cs[0] = 1'b1; we[0] = 1'b1; oe[0] = 1'b1; addr[0] = 2'd2; data[0] = 3'd7;
      step();
      idle(0);
      chk("err_pulse", int'(err[0]), 1);
      chk("err_not_busy", int'(busy[0]), 0);
      step();
      chk("err_single_cycle", int'(err[0]), 0);
      rd(0, 2, 3, 0);

      // Reset one cycle after read acceptance aborts it.
      rd_start(0, 3, 0, 0, 1'b0);
      RESET_N = 1'b0;
      step();
      RESET_N = 1'b1;
      chk("abort_busy", int'(busy[0]), 0);
      chk("abort_out", int'(out[0]), 0);
      chk("abort_valid", int'(ov[0]), 0);
      chk("abort_uninit", int'(un[0]), 0);
      step();
      step();
      rd(0, 0, 0, 1);

      wr(1, 3, 5);
      rd(1, 3, 5, 0);
      rd(1, 3, 5, 0);
      rd(1, 0, 0, 1);

      step();
      step();
      chk("queue_drained_l2", q0.size(), 0);
      chk("queue_drained_l1", q1.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
